// File: rtl/icache_assoc_prefetch.sv
// Set-associative, read-only instruction cache with true-LRU replacement
// and an optional sequential next-line prefetch after each demand fill.
module icache_assoc_prefetch #(
    parameter int SET_W       = 2,
    parameter int WAYS        = 2,
    parameter int PREFETCH_EN = 1
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int SETS  = 1 << SET_W;
    localparam int TAG_W = 28 - SET_W;
    localparam int RW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Rank 0 is MRU, rank WAYS-1 is LRU.
    typedef logic [WAYS-1:0][RW-1:0] rank_t;
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_PREFETCH} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [27:0]       r_pf_addr;
    logic [27:0]       w_pf_next;
    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [127:0]      r_data  [SETS][WAYS];
    rank_t             r_rank  [SETS];

    // Move way w to MRU; ways that were more recent than it age by one.
    function automatic rank_t promote(input rank_t r, input logic [RW-1:0] w);
        rank_t n;
        n = r;
        for (int j = 0; j < WAYS; j++) begin
            if (RW'(j) == w)
                n[j] = '0;
            else if (r[j] < r[w])
                n[j] = r[j] + 1'b1;
        end
        return n;
    endfunction

    function automatic logic [RW-1:0] lru_way(input rank_t r);
        logic [RW-1:0] v;
        v = '0;
        for (int j = 0; j < WAYS; j++)
            if (r[j] == RW'(WAYS - 1))
                v = RW'(j);
        return v;
    endfunction

    // CPU-side address decode.
    logic [27:0]      w_line;
    logic [SET_W-1:0] w_set;
    logic [TAG_W-1:0] w_tag;
    logic [1:0]       w_word;
    assign w_line = proc_addr[29:2];
    assign w_set  = proc_addr[SET_W+1:2];
    assign w_tag  = proc_addr[29:SET_W+2];
    assign w_word = proc_addr[1:0];

    // Second lookup port: next line while filling, pending prefetch line otherwise.
    logic [27:0]      w_probe_line;
    logic [SET_W-1:0] w_probe_set;
    logic [TAG_W-1:0] w_probe_tag;
    assign w_probe_line = (r_state == S_FILL) ? (w_line + 28'd1) : r_pf_addr;
    assign w_probe_set  = w_probe_line[SET_W-1:0];
    assign w_probe_tag  = w_probe_line[27:SET_W];

    logic [WAYS-1:0] w_hit_vec;
    logic [WAYS-1:0] w_probe_vec;
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign w_hit_vec[gi]   = r_valid[w_set][gi] && (r_tag[w_set][gi] == w_tag);
            assign w_probe_vec[gi] = r_valid[w_probe_set][gi] && (r_tag[w_probe_set][gi] == w_probe_tag);
        end
    endgenerate

    logic          w_hit;
    logic          w_probe_hit;
    logic [RW-1:0] w_hit_way;
    logic [31:0]   w_hit_word;
    logic [31:0]   w_mem_word;
    assign w_hit       = |w_hit_vec;
    assign w_probe_hit = |w_probe_vec;
    assign w_hit_word  = r_data[w_set][w_hit_way][{w_word, 5'b0} +: 32];
    assign w_mem_word  = mem_rdata[{w_word, 5'b0} +: 32];

    // One-hot hit vector to way index (tags are unique within a set).
    always_comb begin
        w_hit_way = '0;
        for (int j = 0; j < WAYS; j++)
            if (w_hit_vec[j])
                w_hit_way = RW'(j);
    end

    logic             w_stall;
    logic [31:0]      w_rdata;
    logic             w_mem_read;
    logic [27:0]      w_mem_addr;
    logic             w_hit_upd;
    logic             w_inst_en;
    logic [SET_W-1:0] w_inst_set;
    logic [TAG_W-1:0] w_inst_tag;

    // Next-state, CPU/memory outputs and install/LRU update requests.
    always_comb begin
        w_state_next = r_state;
        w_pf_next    = r_pf_addr;
        w_stall      = 1'b0;
        w_rdata      = '0;
        w_mem_read   = 1'b0;
        w_mem_addr   = '0;
        w_hit_upd    = 1'b0;
        w_inst_en    = 1'b0;
        w_inst_set   = w_set;
        w_inst_tag   = w_tag;
        case (r_state)
            S_IDLE: begin
                if (proc_read) begin
                    if (w_hit) begin
                        w_rdata   = w_hit_word;
                        w_hit_upd = 1'b1;
                    end else begin
                        w_stall      = 1'b1;
                        w_mem_read   = 1'b1;
                        w_mem_addr   = w_line;
                        w_state_next = S_FILL;
                    end
                end
            end
            S_FILL: begin
                w_mem_read = 1'b1;
                w_mem_addr = w_line;
                w_stall    = 1'b1;
                if (mem_ready) begin
                    w_mem_read = 1'b0;
                    w_stall    = 1'b0;
                    w_rdata    = w_mem_word;
                    w_inst_en  = !w_hit;
                    if ((PREFETCH_EN != 0) && !w_probe_hit) begin
                        w_pf_next    = w_probe_line;
                        w_state_next = S_PREFETCH;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_PREFETCH: begin
                w_mem_read = 1'b1;
                w_mem_addr = r_pf_addr;
                w_inst_set = w_probe_set;
                w_inst_tag = w_probe_tag;
                if (proc_read) begin
                    if (w_hit) begin
                        w_rdata   = w_hit_word;
                        w_hit_upd = 1'b1;
                    end else if (mem_ready && (w_line == r_pf_addr)) begin
                        w_rdata = w_mem_word;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
                if (mem_ready) begin
                    w_inst_en = !w_probe_hit;
                    if (proc_read && !w_hit && (w_line != r_pf_addr))
                        w_state_next = S_FILL;
                    else
                        w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    rank_t         w_hit_ranks;
    rank_t         w_base_ranks;
    rank_t         w_inst_ranks;
    logic [RW-1:0] w_victim;

    // A same-cycle hit to the install set is applied before picking the victim.
    always_comb begin
        w_hit_ranks  = promote(r_rank[w_set], w_hit_way);
        w_base_ranks = (w_hit_upd && (w_inst_set == w_set)) ? w_hit_ranks : r_rank[w_inst_set];
        w_victim     = lru_way(w_base_ranks);
        w_inst_ranks = promote(w_base_ranks, w_victim);
    end

    // Control state, valid bits and LRU ranks.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_state   <= S_IDLE;
            r_pf_addr <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    r_rank[s][w] <= RW'(WAYS - 1 - w);
            end
        end else begin
            r_state   <= w_state_next;
            r_pf_addr <= w_pf_next;
            if (w_hit_upd)
                r_rank[w_set] <= w_hit_ranks;
            if (w_inst_en) begin
                r_valid[w_inst_set][w_victim] <= 1'b1;
                r_rank[w_inst_set]            <= w_inst_ranks;
            end
        end
    end

    // Tag and line storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (w_inst_en) begin
            r_tag[w_inst_set][w_victim]  <= w_inst_tag;
            r_data[w_inst_set][w_victim] <= mem_rdata;
        end
    end

    // Writes are not supported; the write-side inputs are deliberately dropped.
    logic w_unused;
    assign w_unused = ^{proc_write, proc_wdata};

    assign proc_rdata = proc_reset ? '0   : w_rdata;
    assign proc_stall = proc_reset ? 1'b0 : w_stall;
    assign mem_read   = proc_reset ? 1'b0 : w_mem_read;
    assign mem_addr   = proc_reset ? '0   : w_mem_addr;
    assign mem_write  = 1'b0;
    assign mem_wdata  = '0;
endmodule

// File: tb/tb_icache_assoc_prefetch.sv
// Directed bench for icache_assoc_prefetch: demand fill, prefetch, LRU,
// forwarding during prefetch, address wrap, reset abort, prefetch disabled.
module tb_icache_assoc_prefetch;
    logic         clk;
    logic         proc_reset;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    // Second instance with prefetch disabled, sharing all inputs.
    logic [31:0]  p2_rdata;
    logic         p2_stall;
    logic         m2_read;
    logic         m2_write;
    logic [27:0]  m2_addr;
    logic [127:0] m2_wdata;

    int total = 0;
    int bad   = 0;

    icache_assoc_prefetch #(.SET_W(2), .WAYS(2), .PREFETCH_EN(1)) dut (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
        .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    icache_assoc_prefetch #(.SET_W(2), .WAYS(2), .PREFETCH_EN(0)) dut_nopf (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(p2_rdata),
        .proc_stall(p2_stall), .mem_read(m2_read), .mem_write(m2_write),
        .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word k of line L is {L, k, 2'b01}.
    function automatic logic [31:0] mk_word(input logic [27:0] line, input logic [1:0] k);
        return {line, k, 2'b01};
    endfunction

    function automatic logic [127:0] mk_line(input logic [27:0] line);
        return {mk_word(line, 2'd3), mk_word(line, 2'd2), mk_word(line, 2'd1), mk_word(line, 2'd0)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Start of a new cycle: just after the rising edge, drop any ready pulse.
    task automatic nc();
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
    endtask

    task automatic hit_rd(input logic [27:0] line, input logic [1:0] w, input logic [31:0] exp);
        nc();
        proc_read = 1'b1;
        proc_addr = {line, w};
        @(negedge clk);
        chk("hit_rdata", proc_rdata, exp);
        chk("hit_stall", proc_stall, 1'b0);
        chk("hit_mem_read", mem_read, 1'b0);
    endtask

    // Demand miss, fill, then (when expected) serve the prefetch of line+1.
    task automatic do_miss(input logic [27:0] line, input logic [1:0] w, input bit pf,
                           input logic [27:0] pf_line, input bit chk_nopf);
        nc();
        proc_read = 1'b1;
        proc_addr = {line, w};
        @(negedge clk);
        chk("miss_stall", proc_stall, 1'b1);
        chk("miss_mem_read", mem_read, 1'b1);
        chk("miss_mem_addr", mem_addr, line);
        nc();
        mem_ready = 1'b1;
        mem_rdata = mk_line(line);
        @(negedge clk);
        chk("fill_rdata", proc_rdata, mk_word(line, w));
        chk("fill_stall", proc_stall, 1'b0);
        chk("fill_mem_read", mem_read, 1'b0);
        nc();
        proc_read = 1'b0;
        @(negedge clk);
        chk("pf_mem_read", mem_read, pf);
        if (chk_nopf)
            chk("nopf_mem_read", m2_read, 1'b0);
        if (pf) begin
            chk("pf_mem_addr", mem_addr, pf_line);
            nc();
            mem_ready = 1'b1;
            mem_rdata = mk_line(pf_line);
            @(negedge clk);
        end
    endtask

    initial begin
        proc_reset = 1'b1;
        proc_read  = 1'b1;
        proc_addr  = '0;
        proc_write = 1'b0;
        proc_wdata = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;

        // Outputs are forced low while reset is held, even with a read pending.
        @(negedge clk);
        chk("rst_stall", proc_stall, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_rdata", proc_rdata, 32'h0);
        nc();
        proc_reset = 1'b0;
        proc_read  = 1'b0;

        // First miss at line 0, prefetch of line 1, then hits across line 1.
        do_miss(28'h0, 2'd0, 1'b1, 28'h1, 1'b0);
        hit_rd(28'h1, 2'd0, 32'h11);
        hit_rd(28'h1, 2'd1, 32'h15);
        hit_rd(28'h1, 2'd2, 32'h19);
        hit_rd(28'h1, 2'd3, 32'h1D);
        hit_rd(28'h0, 2'd2, 32'h9);

        // LRU in set 2: tags 1,2 filled, tag 1 touched, tag 3 evicts tag 2.
        do_miss(28'h6,  2'd0, 1'b1, 28'h7,  1'b0);
        do_miss(28'hA,  2'd0, 1'b1, 28'hB,  1'b0);
        hit_rd(28'h6, 2'd1, 32'h65);
        do_miss(28'hE,  2'd0, 1'b1, 28'hF,  1'b0);
        hit_rd(28'h6, 2'd2, 32'h69);
        // Tag 2 misses again; line 0xB is still cached so no prefetch follows.
        do_miss(28'hA,  2'd2, 1'b0, 28'h0,  1'b0);

        // Hit and forwarded miss while the prefetch of line 0x21 is outstanding.
        nc();
        proc_read = 1'b1;
        proc_addr = {28'h20, 2'd0};
        @(negedge clk);
        chk("m20_stall", proc_stall, 1'b1);
        nc();
        mem_ready = 1'b1;
        mem_rdata = mk_line(28'h20);
        @(negedge clk);
        chk("m20_rdata", proc_rdata, 32'h201);
        nc();
        proc_addr = {28'h20, 2'd3};
        @(negedge clk);
        chk("pfhit_rdata", proc_rdata, 32'h20D);
        chk("pfhit_stall", proc_stall, 1'b0);
        chk("pfhit_mem_addr", mem_addr, 28'h21);
        nc();
        proc_addr = {28'h21, 2'd1};
        @(negedge clk);
        chk("pfmiss_stall", proc_stall, 1'b1);
        chk("pfmiss_mem_read", mem_read, 1'b1);
        chk("pfmiss_mem_addr", mem_addr, 28'h21);
        nc();
        mem_ready = 1'b1;
        mem_rdata = mk_line(28'h21);
        @(negedge clk);
        chk("fwd_stall", proc_stall, 1'b0);
        chk("fwd_rdata", proc_rdata, 32'h215);
        nc();
        @(negedge clk);
        chk("fwd_after_stall", proc_stall, 1'b0);
        chk("fwd_after_mem_read", mem_read, 1'b0);
        chk("fwd_after_rdata", proc_rdata, 32'h215);

        // Reset in the middle of a fill abandons it; a late ready is ignored.
        nc();
        proc_addr = {28'h30, 2'd0};
        @(negedge clk);
        chk("m30_stall", proc_stall, 1'b1);
        nc();
        proc_reset = 1'b1;
        @(negedge clk);
        chk("rstfill_mem_read", mem_read, 1'b0);
        chk("rstfill_stall", proc_stall, 1'b0);
        nc();
        proc_reset = 1'b0;
        proc_read  = 1'b0;
        mem_ready  = 1'b1;
        mem_rdata  = mk_line(28'h30);
        @(negedge clk);
        chk("late_ready_mem_read", mem_read, 1'b0);
        // Same line misses again; the no-prefetch instance stays quiet afterwards.
        do_miss(28'h30, 2'd0, 1'b1, 28'h31, 1'b1);

        // Miss at the top line: prefetch address wraps to line 0.
        do_miss(28'hFFFFFFF, 2'd1, 1'b1, 28'h0, 1'b0);
        nc();
        proc_read = 1'b0;
        @(negedge clk);
        chk("wrap_done_mem_read", mem_read, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
